execute_cycle: RTL and testbench

- RV32I execute stage, directly upstream of the memory stage.
- Selects forwarded operands, runs the ALU, resolves branches and jumps, and computes the redirect target.
- Registers all memory-stage inputs in an EX/MEM pipeline register that supports hold and bubble insertion.
- The optional statistics block adds branch counters.

---
 rtl/execute_cycle.sv | 175 +++++++++++++++++
 tb/tb_execute_cycle.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32I execute stage with EX/MEM pipeline register
//
// Purpose: picks forwarded operands, runs the ALU, resolves branches and
// jumps (redirect is combinational) and registers everything the memory
// stage needs in an EX/MEM register that supports hold and bubble.
//
// Optional feature macro: EX_BRANCH_STATS_EN adds BranchCntM / TakenCntM.
//
// Ports:
//   clk, rst (async, active-low)
//   E-side controls : RegWriteE, MemWriteE, ResultSrcE, MemOpE, ALUControlE,
//                     ALUSrcAE, ALUSrcBE, BranchE, JumpE, JalrE, Funct3E
//   E-side data     : RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RD_E
//   forwarding      : ForwardAE, ForwardBE, ResultW
//   pipeline ctrl   : HoldM, BubbleM
//   redirect        : PCSrcE, PCTargetE (combinational)
//   M-side          : RegWriteM, MemWriteM, ResultSrcM, MemOpM, RD_M,
//                     PCPlus4M, WriteDataM, ALU_ResultM
//   stats (opt)     : BranchCntM, TakenCntM
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [1:0]      MemOpE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcAE,
  input  logic            ALUSrcBE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            HoldM,
  input  logic            BubbleM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [1:0]      MemOpM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
`ifdef EX_BRANCH_STATS_EN
  ,
  output logic [31:0]     BranchCntM,
  output logic [31:0]     TakenCntM
`endif
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            branch_taken;
  logic            slt_bit;
  logic            sltu_bit;

  // Encoding 11 is unused by the hazard unit and falls back to the RF value.
  always_comb begin
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALU_ResultM;
      default: fwd_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_a    = ALUSrcAE ? PCE : fwd_a;
  assign src_b    = ALUSrcBE ? ImmExtE : fwd_b;
  assign shamt    = src_b[4:0];
  assign slt_bit  = $signed(src_a) < $signed(src_b);
  assign sltu_bit = src_a < src_b;

  always_comb begin
    case (ALUControlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(XLEN-1){1'b0}}, slt_bit};
      4'b0110: alu_result = {{(XLEN-1){1'b0}}, sltu_bit};
      4'b0111: alu_result = src_a << shamt;
      4'b1000: alu_result = src_a >> shamt;
      4'b1001: alu_result = $unsigned($signed(src_a) >>> shamt);
      4'b1010: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  // Branches compare the forwarded register operands, never the ALU inputs.
  always_comb begin
    case (Funct3E)
      3'b000:  branch_taken = (fwd_a == fwd_b);
      3'b001:  branch_taken = (fwd_a != fwd_b);
      3'b100:  branch_taken = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  branch_taken = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  branch_taken = (fwd_a <  fwd_b);
      3'b111:  branch_taken = (fwd_a >= fwd_b);
      default: branch_taken = 1'b0;
    endcase
  end

  // Redirect is left ungated; the hazard unit decides whether to honour it.
  assign PCSrcE    = JumpE | (BranchE & branch_taken);
  assign PCTargetE = JalrE ? ((fwd_a + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                           : (PCE + ImmExtE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      MemOpM      <= 2'b00;
      RD_M        <= 5'd0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (BubbleM) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      MemOpM      <= 2'b00;
      RD_M        <= 5'd0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (!HoldM) begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      MemOpM      <= MemOpE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

`ifdef EX_BRANCH_STATS_EN
  // Counts only instructions that actually enter the memory stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BranchCntM <= 32'd0;
      TakenCntM  <= 32'd0;
    end else if (!BubbleM && !HoldM && BranchE) begin
      BranchCntM <= BranchCntM + 32'd1;
      if (branch_taken) begin
        TakenCntM <= TakenCntM + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - self-checking bench for execute_cycle
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE, MemOpE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE, BranchE, JumpE, JalrE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        HoldM, BubbleM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM, MemOpM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
`ifdef EX_BRANCH_STATS_EN
  logic [31:0] BranchCntM, TakenCntM;
`endif

  int checks = 0;
  int failures = 0;

  execute_cycle #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .MemOpE(MemOpE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .HoldM(HoldM), .BubbleM(BubbleM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .MemOpM(MemOpM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
`ifdef EX_BRANCH_STATS_EN
    , .BranchCntM(BranchCntM), .TakenCntM(TakenCntM)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected EX/MEM register contents
  logic        m_rw, m_mw;
  logic [1:0]  m_rs, m_mo;
  logic [4:0]  m_rd;
  logic [31:0] m_pc4, m_wd, m_alu;

  task automatic model_clear();
    m_rw = 0; m_mw = 0; m_rs = 0; m_mo = 0; m_rd = 0; m_pc4 = 0; m_wd = 0; m_alu = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".RegWriteM"},   {31'd0, RegWriteM}, {31'd0, m_rw});
    check({tag, ".MemWriteM"},   {31'd0, MemWriteM}, {31'd0, m_mw});
    check({tag, ".ResultSrcM"},  {30'd0, ResultSrcM}, {30'd0, m_rs});
    check({tag, ".MemOpM"},      {30'd0, MemOpM}, {30'd0, m_mo});
    check({tag, ".RD_M"},        {27'd0, RD_M}, {27'd0, m_rd});
    check({tag, ".PCPlus4M"},    PCPlus4M, m_pc4);
    check({tag, ".WriteDataM"},  WriteDataM, m_wd);
    check({tag, ".ALU_ResultM"}, ALU_ResultM, m_alu);
  endtask

  // Reference model written from the instruction-set rules
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s = b % 32;
    logic [31:0] ones = 32'hFFFF_FFFF;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 1);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd7:  return 32'(longint'(a) * (64'd1 << s));
      4'd8:  return 32'(longint'(a) / (64'd1 << s));
      4'd9:  return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa = int'(a);
    int sb = int'(b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // Uses current inputs and expected M state; returns predicted redirect and
  // advances the model as one clock edge would.
  task automatic model_eval(output logic pcsrc, output logic [31:0] tgt);
    logic [31:0] fa, fb, a, b;
    fa = ref_fwd(ForwardAE, RD1E, ResultW, m_alu);
    fb = ref_fwd(ForwardBE, RD2E, ResultW, m_alu);
    a = ALUSrcAE ? PCE : fa;
    b = ALUSrcBE ? ImmExtE : fb;
    pcsrc = JumpE || (BranchE && ref_cond(Funct3E, fa, fb));
    tgt = JalrE ? ((fa + ImmExtE) / 2) * 2 : PCE + ImmExtE;
  endtask

  task automatic model_step();
    logic [31:0] fa, fb, a, b;
    fa = ref_fwd(ForwardAE, RD1E, ResultW, m_alu);
    fb = ref_fwd(ForwardBE, RD2E, ResultW, m_alu);
    a = ALUSrcAE ? PCE : fa;
    b = ALUSrcBE ? ImmExtE : fb;
    if (BubbleM) model_clear();
    else if (!HoldM) begin
      m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_mo = MemOpE;
      m_rd = RD_E; m_pc4 = PCPlus4E; m_wd = fb; m_alu = ref_alu(ALUControlE, a, b);
    end
  endtask

  task automatic idle_inputs();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; MemOpE = 0; ALUControlE = 0;
    ALUSrcAE = 0; ALUSrcBE = 0; BranchE = 0; JumpE = 0; JalrE = 0; Funct3E = 0;
    RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0; HoldM = 0; BubbleM = 0;
  endtask

  typedef struct {
    logic [3:0] op; logic sa; logic sb; logic [1:0] fa; logic [1:0] fb;
    logic br; logic jp; logic jr; logic [2:0] f3;
    logic [31:0] rd1; logic [31:0] rd2; logic [31:0] imm; logic [31:0] pc; logic [31:0] resw;
    logic [4:0] rd; logic regw;
    logic [31:0] x_alu; logic [31:0] x_wd; logic x_pcsrc; logic [31:0] x_tgt;
  } vec_t;

  vec_t vt[11];
  logic        p_src;
  logic [31:0] p_tgt;

  initial begin
    vt[0]  = '{4'h0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'd5, 32'd0, 32'd7, 32'd0, 32'd0, 5'd3, 1,
               32'd12, 32'd0, 0, 32'd7};
    vt[1]  = '{4'hA, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h100, 32'd0, 32'd0, 5'd1, 1,
               32'h100, 32'd0, 0, 32'h100};
    vt[2]  = '{4'h1, 0, 0, 2, 1, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h20, 5'd2, 1,
               32'hE0, 32'h20, 0, 32'd0};
    vt[3]  = '{4'h0, 0, 0, 0, 0, 1, 0, 0, 3'd0, 32'h55, 32'h55, 32'hFFFF_FFF8, 32'h40, 32'd0, 5'd0, 0,
               32'hAA, 32'h55, 1, 32'h38};
    vt[4]  = '{4'h0, 0, 0, 0, 0, 1, 0, 0, 3'd1, 32'h55, 32'h55, 32'hFFFF_FFF8, 32'h40, 32'd0, 5'd0, 0,
               32'hAA, 32'h55, 0, 32'h38};
    vt[5]  = '{4'h0, 0, 1, 0, 0, 0, 1, 1, 3'd0, 32'h1003, 32'd0, 32'd4, 32'h200, 32'd0, 5'd1, 1,
               32'h1007, 32'd0, 1, 32'h1006};
    vt[6]  = '{4'h9, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'd0, 5'd5, 1,
               32'hF800_0000, 32'd0, 0, 32'd4};
    vt[7]  = '{4'h6, 0, 0, 0, 0, 1, 0, 0, 3'd6, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h100, 32'd0, 5'd7, 1,
               32'd1, 32'hFFFF_FFFF, 1, 32'h110};
    vt[8]  = '{4'h5, 0, 0, 0, 0, 1, 0, 0, 3'd4, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h100, 32'd0, 5'd7, 1,
               32'd0, 32'hFFFF_FFFF, 0, 32'h110};
    vt[9]  = '{4'h0, 0, 0, 3, 3, 1, 0, 0, 3'd2, 32'd3, 32'd3, 32'd0, 32'd0, 32'h77, 5'd9, 1,
               32'd6, 32'd3, 0, 32'd0};
    vt[10] = '{4'hF, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'd9, 32'd0, 32'd5, 32'd0, 32'd0, 5'd4, 0,
               32'd0, 32'd0, 0, 32'd5};

    idle_inputs();
    model_clear();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    @(negedge clk) rst = 1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      ALUControlE = vt[i].op; ALUSrcAE = vt[i].sa; ALUSrcBE = vt[i].sb;
      ForwardAE = vt[i].fa; ForwardBE = vt[i].fb; BranchE = vt[i].br;
      JumpE = vt[i].jp; JalrE = vt[i].jr; Funct3E = vt[i].f3;
      RD1E = vt[i].rd1; RD2E = vt[i].rd2; ImmExtE = vt[i].imm; PCE = vt[i].pc;
      PCPlus4E = vt[i].pc + 4; ResultW = vt[i].resw; RD_E = vt[i].rd; RegWriteE = vt[i].regw;
      #1;
      check($sformatf("vec%0d.PCSrcE", i), {31'd0, PCSrcE}, {31'd0, vt[i].x_pcsrc});
      check($sformatf("vec%0d.PCTargetE", i), PCTargetE, vt[i].x_tgt);
      @(posedge clk); #1;
      check($sformatf("vec%0d.ALU_ResultM", i), ALU_ResultM, vt[i].x_alu);
      check($sformatf("vec%0d.WriteDataM", i), WriteDataM, vt[i].x_wd);
      check($sformatf("vec%0d.RD_M", i), {27'd0, RD_M}, {27'd0, vt[i].rd});
      check($sformatf("vec%0d.RegWriteM", i), {31'd0, RegWriteM}, {31'd0, vt[i].regw});
      check($sformatf("vec%0d.PCPlus4M", i), PCPlus4M, vt[i].pc + 4);
      @(negedge clk);
    end

    // Hold for two cycles while inputs change
    idle_inputs();
    ALUControlE = 4'hA; ALUSrcBE = 1; ImmExtE = 32'hABCD; RD_E = 5'd17; RegWriteE = 1;
    MemWriteE = 1; ResultSrcE = 2'd2; MemOpE = 2'd1; PCPlus4E = 32'h44; RD2E = 32'h1234;
    model_step();
    @(negedge clk);
    check_regs("preload");
    HoldM = 1;
    for (int k = 0; k < 2; k++) begin
      ImmExtE = $urandom; RD_E = 5'($urandom); PCPlus4E = $urandom; RD2E = $urandom;
      RegWriteE = 0; MemWriteE = 0; ResultSrcE = 2'd1; MemOpE = 2'd2;
      @(negedge clk);
      check_regs($sformatf("hold%0d", k));
    end
    BubbleM = 1;
    model_clear();
    @(negedge clk);
    check_regs("hold_bubble");

    // Asynchronous reset between edges
    idle_inputs();
    ALUControlE = 4'hA; ALUSrcBE = 1; ImmExtE = 32'h5A5A; RD_E = 5'd8; RegWriteE = 1;
    model_step();
    @(negedge clk);
    check_regs("preload2");
    #2 rst = 0;
    model_clear();
    #1 check_regs("async_rst");
    @(negedge clk) rst = 1;
    idle_inputs();

`ifdef EX_BRANCH_STATS_EN
    // Three loaded branches (two taken) and one bubbled branch
    BranchE = 1; RD1E = 32'h9; RD2E = 32'h9;
    for (int k = 0; k < 4; k++) begin
      Funct3E = (k == 1) ? 3'd1 : 3'd0;
      BubbleM = (k == 3);
      @(negedge clk);
    end
    check("stats.BranchCntM", BranchCntM, 32'd3);
    check("stats.TakenCntM", TakenCntM, 32'd2);
    idle_inputs();
    model_clear();
    @(negedge clk);
`endif

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      ResultSrcE = 2'($urandom); MemOpE = 2'($urandom);
      ALUControlE = 4'($urandom); ALUSrcAE = 1'($urandom); ALUSrcBE = 1'($urandom);
      BranchE = 1'($urandom); JumpE = ($urandom_range(0, 3) == 0); JalrE = 1'($urandom);
      Funct3E = 3'($urandom);
      RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      ImmExtE = $urandom; PCE = $urandom; PCPlus4E = PCE + 4; RD_E = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
      HoldM = ($urandom_range(0, 5) == 0); BubbleM = ($urandom_range(0, 7) == 0);
      #1;
      model_eval(p_src, p_tgt);
      check($sformatf("rnd%0d.PCSrcE", i), {31'd0, PCSrcE}, {31'd0, p_src});
      check($sformatf("rnd%0d.PCTargetE", i), PCTargetE, p_tgt);
      model_step();
      @(posedge clk); #1;
      check_regs($sformatf("rnd%0d", i));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
